cpu_lsu: RTL and testbench
==========================

// Module: cpu_lsu
// PURPOSE
//  Load/store unit between the pipeline memory stage (Q4) and a valid/ready data bus.
//  Accepts one access from Q4, builds byte strobes, replicates store lanes, aligns and extends load data.
//  Holds the pipeline via o_stall until the access completes, then returns a one-cycle response.
//  Replaces the direct single-cycle data memory hookup so that wait-stated memories and peripherals work.
// PARAMETERS
//  TIMEOUT_CYCLES  256  bus watchdog limit in cycles spent in REQ+WAIT; 0 disables the watchdog
// PORTS
//  i_clk          in   1   clock
//  i_rst          in   1   synchronous reset, active-high
//  i_req_valid    in   1   Q4 access request
//  o_req_ready    out  1   high in IDLE only
//  i_req_we       in   1   1=store, 0=load
//  i_req_funct3   in   3   RV32I size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
//  i_req_addr     in   32  byte address (ALU result)
//  i_req_wdata    in   32  store data (rs2, already forwarded)
//  o_stall        out  1   pipeline hold; comb = (IDLE & i_req_valid) | REQ | WAIT
//  o_resp_valid   out  1   one-cycle completion pulse
//  o_resp_rdata   out  32  aligned, extended load data; 0 for stores or errors
//  o_resp_err     out  1   access failed; qualified by o_resp_valid
//  o_resp_cause   out  2   lsu_cause_t: 0 NONE, 1 BUSERR, 2 TIMEOUT, 3 MISALIGN
//  o_bus_valid    out  1   bus request
//  i_bus_ready    in   1   bus accepts request
//  o_bus_we       out  1   write enable
//  o_bus_addr     out  32  word address {addr[31:2],2'b00}
//  o_bus_wdata    out  32  lane-replicated store data
//  o_bus_wstrb    out  4   byte strobes; 0 for reads
//  i_bus_rvalid   in   1   read data valid
//  i_bus_rdata    in   32  read data
//  i_bus_err      in   1   error; sampled with the ready handshake (writes) or with rvalid (reads)
// BEHAVIOUR
//  Reset: state IDLE; o_bus_valid, o_resp_valid, o_resp_err = 0; o_resp_cause = NONE;
//   o_resp_rdata, o_bus_addr, o_bus_wdata, o_bus_wstrb, o_bus_we = 0; timeout counter = 0.
//  FSM:
//   IDLE: o_req_ready=1. If i_req_valid, latch we/funct3/addr/wdata.
//    Misaligned with CPU_LSU_MISALIGN_EXC_EN -> DONE, else -> REQ.
//   REQ: o_bus_valid=1; addr, we, wdata, wstrb stay stable until i_bus_ready.
//    On handshake: write -> DONE (cause BUSERR if i_bus_err).
//    Read with i_bus_rvalid in the same cycle -> DONE (zero-wait read). Read otherwise -> WAIT.
//   WAIT: on i_bus_rvalid, capture and extend data -> DONE (cause BUSERR if i_bus_err).
//   DONE: o_resp_valid=1 for exactly one cycle -> IDLE. The next request is accepted the cycle after.
//  Latency: a zero-wait read or write gives o_resp_valid 2 cycles after IDLE acceptance.
//   Each wait cycle adds one cycle.
//  Size (funct3[1:0]): 00 byte, 01 half, 10 word. Reserved 011/110/111 are treated as word.
//  Store lanes: B -> wdata={4{wdata[7:0]}}, wstrb=4'b0001<<addr[1:0];
//   H -> {2{wdata[15:0]}}, wstrb=4'b0011<<{addr[1],1'b0}; W -> wstrb=4'b1111.
//  Load data: shift rdata right by 8*addr[1:0]; funct3[2]=0 sign-extends, funct3[2]=1 zero-extends.
//  Watchdog: counter cleared on REQ entry and increments every REQ/WAIT cycle.
//   With no progress at count==TIMEOUT_CYCLES-1: go to DONE with cause TIMEOUT; o_bus_valid drops.
//   A handshake or rvalid in that same cycle wins over the timeout.
//  i_bus_rvalid outside WAIT/REQ is ignored; so is a late response after a timeout or reset.
//  A reset mid-access returns IDLE at the next edge, drops o_bus_valid, and gives no o_resp_valid.
//  A request held during DONE is not accepted until IDLE; o_stall stays low in DONE.
// CONFIGURATION
//  CPU_LSU_MISALIGN_EXC_EN defined: a half access with addr[0]!=0 or a word access with addr[1:0]!=0
//   issues no bus transaction. DONE follows IDLE directly with err=1, cause=MISALIGN.
//  Undefined: misalignment is not checked; the offending low address bits are cleared
//   (half: addr[0]; word: addr[1:0]) and the access proceeds. MISALIGN is never reported.
// STRUCTURE
//  cpu_types package: lsu_state_t (IDLE, REQ, WAIT, DONE), lsu_cause_t, LSU size/funct3 constants.
//  Sub-module lsu_align (combinational): strobe/lane-replication and load extract/extend.
//  The FSM, latches and watchdog live in cpu_lsu.
// TESTING
//  LB 0x103, rdata 0x80AABBCC -> bus_addr 0x100, wstrb 0, resp_rdata 0xFFFFFF80; LBU -> 0x00000080.
//  SH 0x202, wdata 0x1234ABCD -> bus_wdata 0xABCDABCD, wstrb 4'b1100, resp 1 cycle after ready.
//  LW 0x40, ready+rvalid same cycle -> resp_valid 2 cycles after acceptance; ready 3 cycles late -> 5 cycles.
//  TIMEOUT_CYCLES=4, ready held 0 -> 4 REQ cycles, then resp err=1, cause=2; later rvalid ignored.
//  LW 0x102: macro on -> no bus_valid, resp cause=3; macro off -> bus_addr 0x100, normal read.
//  i_rst pulsed in WAIT -> IDLE next cycle, o_stall=0, no resp_valid, late rvalid ignored.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared LSU types: FSM states, response causes, access sizes and RV32I
// load/store funct3 encodings, plus the funct3 -> size decode helper.
package cpu_types;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'd0,
        LSU_REQ  = 2'd1,
        LSU_WAIT = 2'd2,
        LSU_DONE = 2'd3
    } lsu_state_t;

    typedef enum logic [1:0] {
        CAUSE_NONE     = 2'd0,
        CAUSE_BUSERR   = 2'd1,
        CAUSE_TIMEOUT  = 2'd2,
        CAUSE_MISALIGN = 2'd3
    } lsu_cause_t;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'b00,
        SIZE_HALF = 2'b01,
        SIZE_WORD = 2'b10
    } lsu_size_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Reserved encodings (011, 110, 111) fall through to word.
    function automatic lsu_size_t lsu_size(input logic [2:0] funct3);
        case (funct3[1:0])
            2'b00:   return SIZE_BYTE;
            2'b01:   return SIZE_HALF;
            default: return SIZE_WORD;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational data-path helpers for the LSU: store byte strobes and lane
// replication, load lane extraction with sign/zero extension.
module lsu_align
    import cpu_types::*;
(
    input  logic [1:0]  st_size,
    input  logic [1:0]  st_off,
    input  logic [31:0] st_wdata,
    output logic [31:0] st_lane_wdata,
    output logic [3:0]  st_wstrb,
    input  logic [2:0]  ld_funct3,
    input  logic [1:0]  ld_off,
    input  logic [31:0] ld_rdata,
    output logic [31:0] ld_data
);

    logic [31:0] ld_shifted;
    logic        ld_signed;

    // Store side: replicate the low lanes across the word and place the strobe.
    always_comb begin
        st_lane_wdata = st_wdata;
        st_wstrb      = 4'b1111;
        case (st_size)
            SIZE_BYTE: begin
                st_lane_wdata = {4{st_wdata[7:0]}};
                st_wstrb      = 4'b0001 << st_off;
            end
            SIZE_HALF: begin
                st_lane_wdata = {2{st_wdata[15:0]}};
                st_wstrb      = 4'b0011 << {st_off[1], 1'b0};
            end
            default: begin
                st_lane_wdata = st_wdata;
                st_wstrb      = 4'b1111;
            end
        endcase
    end

    // Load side: bring the addressed lane down to bit 0, then extend.
    always_comb begin
        ld_shifted = ld_rdata >> {ld_off, 3'b000};
        ld_signed  = ~ld_funct3[2];
        ld_data    = ld_shifted;
        case (lsu_size(ld_funct3))
            SIZE_BYTE: ld_data = {{24{ld_signed & ld_shifted[7]}}, ld_shifted[7:0]};
            SIZE_HALF: ld_data = {{16{ld_signed & ld_shifted[15]}}, ld_shifted[15:0]};
            default:   ld_data = ld_shifted;
        endcase
    end

endmodule

// File: rtl/cpu_lsu.sv
// Load/store unit between the Q4 memory stage and a valid/ready data bus.
// Holds the pipeline until the bus access completes and returns a one-cycle
// response with aligned, extended load data or an error cause.
// Optional build macro CPU_LSU_MISALIGN_EXC_EN: misaligned half/word accesses
// are rejected without a bus transaction (cause MISALIGN). Without it, the
// offending low address bits are cleared and the access proceeds.
module cpu_lsu
    import cpu_types::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_we,
    input  logic [2:0]  i_req_funct3,
    input  logic [31:0] i_req_addr,
    input  logic [31:0] i_req_wdata,
    output logic        o_stall,
    output logic        o_resp_valid,
    output logic [31:0] o_resp_rdata,
    output logic        o_resp_err,
    output logic [1:0]  o_resp_cause,
    output logic        o_bus_valid,
    input  logic        i_bus_ready,
    output logic        o_bus_we,
    output logic [31:0] o_bus_addr,
    output logic [31:0] o_bus_wdata,
    output logic [3:0]  o_bus_wstrb,
    input  logic        i_bus_rvalid,
    input  logic [31:0] i_bus_rdata,
    input  logic        i_bus_err
);

    localparam int unsigned CNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int unsigned CNT_LAST = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

    lsu_state_t  state;
    logic        lat_we;
    logic [2:0]  lat_funct3;
    logic [1:0]  lat_off;
    logic [CNT_W-1:0] wd_cnt;

    lsu_size_t   req_size;
    logic [1:0]  req_off;
    logic        req_misaligned;
    logic [31:0] st_lane_wdata;
    logic [3:0]  st_wstrb;
    logic [31:0] ld_data;
    logic        wd_expired;

    // Handshake outputs that depend on the live request.
    always_comb begin
        o_req_ready = (state == LSU_IDLE);
        o_stall     = ((state == LSU_IDLE) && i_req_valid) ||
                      (state == LSU_REQ) || (state == LSU_WAIT);
    end

    // Request decode: size, effective byte offset and misalignment.
    always_comb begin
        req_size       = lsu_size(i_req_funct3);
        req_off        = i_req_addr[1:0];
        req_misaligned = ((req_size == SIZE_HALF) && i_req_addr[0]) ||
                         ((req_size == SIZE_WORD) && (i_req_addr[1:0] != 2'b00));
`ifndef CPU_LSU_MISALIGN_EXC_EN
        case (req_size)
            SIZE_HALF: req_off = {i_req_addr[1], 1'b0};
            SIZE_WORD: req_off = 2'b00;
            default:   req_off = i_req_addr[1:0];
        endcase
`endif
    end

    // Watchdog fires on the last allowed REQ/WAIT cycle; 0 disables it.
    always_comb begin
        wd_expired = (TIMEOUT_CYCLES != 0) && (wd_cnt == CNT_W'(CNT_LAST));
    end

    lsu_align u_align (
        .st_size       (req_size),
        .st_off        (req_off),
        .st_wdata      (i_req_wdata),
        .st_lane_wdata (st_lane_wdata),
        .st_wstrb      (st_wstrb),
        .ld_funct3     (lat_funct3),
        .ld_off        (lat_off),
        .ld_rdata      (i_bus_rdata),
        .ld_data       (ld_data)
    );

    // Access FSM with request latches, bus outputs, response and watchdog.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state        <= LSU_IDLE;
            lat_we       <= 1'b0;
            lat_funct3   <= '0;
            lat_off      <= '0;
            wd_cnt       <= '0;
            o_bus_valid  <= 1'b0;
            o_bus_we     <= 1'b0;
            o_bus_addr   <= '0;
            o_bus_wdata  <= '0;
            o_bus_wstrb  <= '0;
            o_resp_valid <= 1'b0;
            o_resp_err   <= 1'b0;
            o_resp_cause <= CAUSE_NONE;
            o_resp_rdata <= '0;
        end else begin
            o_resp_valid <= 1'b0;
            case (state)
                LSU_IDLE: begin
                    if (i_req_valid) begin
                        lat_we      <= i_req_we;
                        lat_funct3  <= i_req_funct3;
                        lat_off     <= req_off;
                        wd_cnt      <= '0;
                        o_bus_we    <= i_req_we;
                        o_bus_addr  <= {i_req_addr[31:2], 2'b00};
                        o_bus_wdata <= st_lane_wdata;
                        o_bus_wstrb <= i_req_we ? st_wstrb : 4'b0000;
`ifdef CPU_LSU_MISALIGN_EXC_EN
                        if (req_misaligned) begin
                            state        <= LSU_DONE;
                            o_resp_valid <= 1'b1;
                            o_resp_err   <= 1'b1;
                            o_resp_cause <= CAUSE_MISALIGN;
                            o_resp_rdata <= '0;
                        end else begin
                            state       <= LSU_REQ;
                            o_bus_valid <= 1'b1;
                        end
`else
                        state       <= LSU_REQ;
                        o_bus_valid <= 1'b1;
`endif
                    end
                end
                LSU_REQ: begin
                    wd_cnt <= wd_cnt + CNT_W'(1);
                    if (i_bus_ready) begin
                        o_bus_valid <= 1'b0;
                        if (lat_we) begin
                            state        <= LSU_DONE;
                            o_resp_valid <= 1'b1;
                            o_resp_err   <= i_bus_err;
                            o_resp_cause <= i_bus_err ? CAUSE_BUSERR : CAUSE_NONE;
                            o_resp_rdata <= '0;
                        end else if (i_bus_rvalid) begin
                            state        <= LSU_DONE;
                            o_resp_valid <= 1'b1;
                            o_resp_err   <= i_bus_err;
                            o_resp_cause <= i_bus_err ? CAUSE_BUSERR : CAUSE_NONE;
                            o_resp_rdata <= i_bus_err ? '0 : ld_data;
                        end else begin
                            state <= LSU_WAIT;
                        end
                    end else if (wd_expired) begin
                        state        <= LSU_DONE;
                        o_bus_valid  <= 1'b0;
                        o_resp_valid <= 1'b1;
                        o_resp_err   <= 1'b1;
                        o_resp_cause <= CAUSE_TIMEOUT;
                        o_resp_rdata <= '0;
                    end
                end
                LSU_WAIT: begin
                    wd_cnt <= wd_cnt + CNT_W'(1);
                    if (i_bus_rvalid) begin
                        state        <= LSU_DONE;
                        o_resp_valid <= 1'b1;
                        o_resp_err   <= i_bus_err;
                        o_resp_cause <= i_bus_err ? CAUSE_BUSERR : CAUSE_NONE;
                        o_resp_rdata <= i_bus_err ? '0 : ld_data;
                    end else if (wd_expired) begin
                        state        <= LSU_DONE;
                        o_resp_valid <= 1'b1;
                        o_resp_err   <= 1'b1;
                        o_resp_cause <= CAUSE_TIMEOUT;
                        o_resp_rdata <= '0;
                    end
                end
                LSU_DONE: begin
                    state <= LSU_IDLE;
                end
                default: begin
                    state <= LSU_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_lsu.sv
// Directed self-checking bench for cpu_lsu with a scripted bus responder.
// Build with CPU_LSU_MISALIGN_EXC_EN defined to exercise the misalign path.
module tb_cpu_lsu;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_req_valid;
    logic        o_req_ready;
    logic        i_req_we;
    logic [2:0]  i_req_funct3;
    logic [31:0] i_req_addr;
    logic [31:0] i_req_wdata;
    logic        o_stall;
    logic        o_resp_valid;
    logic [31:0] o_resp_rdata;
    logic        o_resp_err;
    logic [1:0]  o_resp_cause;
    logic        o_bus_valid;
    logic        i_bus_ready;
    logic        o_bus_we;
    logic [31:0] o_bus_addr;
    logic [31:0] o_bus_wdata;
    logic [3:0]  o_bus_wstrb;
    logic        i_bus_rvalid;
    logic [31:0] i_bus_rdata;
    logic        i_bus_err;

    int checks   = 0;
    int failures = 0;

    cpu_lsu #(.TIMEOUT_CYCLES(4)) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_req_valid  (i_req_valid),
        .o_req_ready  (o_req_ready),
        .i_req_we     (i_req_we),
        .i_req_funct3 (i_req_funct3),
        .i_req_addr   (i_req_addr),
        .i_req_wdata  (i_req_wdata),
        .o_stall      (o_stall),
        .o_resp_valid (o_resp_valid),
        .o_resp_rdata (o_resp_rdata),
        .o_resp_err   (o_resp_err),
        .o_resp_cause (o_resp_cause),
        .o_bus_valid  (o_bus_valid),
        .i_bus_ready  (i_bus_ready),
        .o_bus_we     (o_bus_we),
        .o_bus_addr   (o_bus_addr),
        .o_bus_wdata  (o_bus_wdata),
        .o_bus_wstrb  (o_bus_wstrb),
        .i_bus_rvalid (i_bus_rvalid),
        .i_bus_rdata  (i_bus_rdata),
        .i_bus_err    (i_bus_err)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic bus_idle();
        i_bus_ready  = 1'b0;
        i_bus_rvalid = 1'b0;
        i_bus_err    = 1'b0;
        i_bus_rdata  = '0;
    endtask

    // Issue one access from IDLE (called #1 after a rising edge) and script
    // the bus: ready on cycle 1+ready_lat, rvalid rv_lat cycles after that.
    task automatic run_access(
        input string       name,
        input logic        we,
        input logic [2:0]  f3,
        input logic [31:0] addr,
        input logic [31:0] wdata,
        input logic [31:0] rdata,
        input int          ready_lat,
        input int          rv_lat,
        input logic        err,
        input int          exp_lat,
        input int          exp_busv,
        input logic [31:0] exp_addr,
        input logic [31:0] exp_wdata,
        input logic [3:0]  exp_wstrb,
        input logic [31:0] exp_rdata,
        input logic        exp_err,
        input logic [1:0]  exp_cause
    );
        int          c;
        int          busv;
        int          lat;
        logic        got_resp;
        logic [31:0] cap_addr;
        logic [31:0] cap_wdata;
        logic [3:0]  cap_wstrb;
        logic        cap_we;
        logic [31:0] r_rdata;
        logic        r_err;
        logic [1:0]  r_cause;

        busv = 0; lat = 0; got_resp = 1'b0;
        cap_addr = '0; cap_wdata = '0; cap_wstrb = '0; cap_we = 1'b0;
        r_rdata = '0; r_err = 1'b0; r_cause = '0;

        i_req_valid  = 1'b1;
        i_req_we     = we;
        i_req_funct3 = f3;
        i_req_addr   = addr;
        i_req_wdata  = wdata;
        @(posedge i_clk); #1;
        i_req_valid = 1'b0;
        c = 1;
        while (!got_resp && c <= 40) begin
            i_bus_ready  = (c == 1 + ready_lat);
            i_bus_rvalid = !we && (c == 1 + ready_lat + rv_lat);
            i_bus_err    = err && (we ? i_bus_ready : i_bus_rvalid);
            i_bus_rdata  = rdata;
            @(negedge i_clk);
            if (o_bus_valid) begin
                if (busv == 0) begin
                    cap_addr  = o_bus_addr;
                    cap_wdata = o_bus_wdata;
                    cap_wstrb = o_bus_wstrb;
                    cap_we    = o_bus_we;
                end
                busv++;
            end
            if (o_resp_valid) begin
                got_resp = 1'b1;
                lat      = c;
                r_rdata  = o_resp_rdata;
                r_err    = o_resp_err;
                r_cause  = o_resp_cause;
            end else begin
                @(posedge i_clk); #1;
                c++;
            end
        end
        bus_idle();
        check({name, ".resp_seen"}, 32'(got_resp), 32'd1);
        check({name, ".latency"}, lat, exp_lat);
        check({name, ".bus_valid_cycles"}, busv, exp_busv);
        if (exp_busv > 0) begin
            check({name, ".bus_addr"}, cap_addr, exp_addr);
            check({name, ".bus_we"}, 32'(cap_we), 32'(we));
            check({name, ".bus_wstrb"}, 32'(cap_wstrb), 32'(exp_wstrb));
            if (we) check({name, ".bus_wdata"}, cap_wdata, exp_wdata);
        end
        check({name, ".resp_rdata"}, r_rdata, exp_rdata);
        check({name, ".resp_err"}, 32'(r_err), 32'(exp_err));
        check({name, ".resp_cause"}, 32'(r_cause), 32'(exp_cause));
        @(posedge i_clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_time_limit got=running exp=finished");
        $fatal(1, "time limit");
    end

    initial begin
        i_rst        = 1'b1;
        i_req_valid  = 1'b0;
        i_req_we     = 1'b0;
        i_req_funct3 = '0;
        i_req_addr   = '0;
        i_req_wdata  = '0;
        bus_idle();
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        check("reset.req_ready", 32'(o_req_ready), 32'd1);
        check("reset.stall", 32'(o_stall), 32'd0);
        check("reset.bus_valid", 32'(o_bus_valid), 32'd0);
        check("reset.resp_valid", 32'(o_resp_valid), 32'd0);
        check("reset.resp_cause", 32'(o_resp_cause), 32'd0);
        check("reset.bus_addr", o_bus_addr, 32'd0);
        check("reset.bus_wstrb", 32'(o_bus_wstrb), 32'd0);
        @(posedge i_clk); #1;
        i_rst = 1'b0;
        @(posedge i_clk); #1;

        // name we f3 addr wdata rdata rlat rvlat err | lat busv addr wdata wstrb rdata err cause
        run_access("lb_neg",   1'b0, 3'b000, 32'h103, 32'h0, 32'h80AABBCC, 0, 0, 1'b0,
                   2, 1, 32'h100, 32'h0, 4'h0, 32'hFFFFFF80, 1'b0, 2'd0);
        run_access("lbu",      1'b0, 3'b100, 32'h103, 32'h0, 32'h80AABBCC, 0, 0, 1'b0,
                   2, 1, 32'h100, 32'h0, 4'h0, 32'h00000080, 1'b0, 2'd0);
        run_access("sh_hi",    1'b1, 3'b001, 32'h202, 32'h1234ABCD, 32'h0, 0, 0, 1'b0,
                   2, 1, 32'h200, 32'hABCDABCD, 4'hC, 32'h0, 1'b0, 2'd0);
        run_access("sb_lane1", 1'b1, 3'b000, 32'h101, 32'h000000A5, 32'h0, 2, 0, 1'b0,
                   4, 3, 32'h100, 32'hA5A5A5A5, 4'h2, 32'h0, 1'b0, 2'd0);
        run_access("lw_zw",    1'b0, 3'b010, 32'h40, 32'h0, 32'hDEADBEEF, 0, 0, 1'b0,
                   2, 1, 32'h40, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0, 2'd0);
        run_access("lw_rdy3",  1'b0, 3'b010, 32'h40, 32'h0, 32'hCAFEF00D, 3, 0, 1'b0,
                   5, 4, 32'h40, 32'h0, 4'h0, 32'hCAFEF00D, 1'b0, 2'd0);
        run_access("lh_wait2", 1'b0, 3'b001, 32'h102, 32'h0, 32'h80017FFF, 0, 2, 1'b0,
                   4, 1, 32'h100, 32'h0, 4'h0, 32'hFFFF8001, 1'b0, 2'd0);
        run_access("lhu",      1'b0, 3'b101, 32'h102, 32'h0, 32'h80017FFF, 0, 0, 1'b0,
                   2, 1, 32'h100, 32'h0, 4'h0, 32'h00008001, 1'b0, 2'd0);
        run_access("sw_err",   1'b1, 3'b010, 32'h10, 32'h55667788, 32'h0, 0, 0, 1'b1,
                   2, 1, 32'h10, 32'h55667788, 4'hF, 32'h0, 1'b1, 2'd1);
        run_access("lw_err",   1'b0, 3'b010, 32'h44, 32'h0, 32'h12345678, 1, 1, 1'b1,
                   4, 2, 32'h44, 32'h0, 4'h0, 32'h0, 1'b1, 2'd1);
        run_access("lw_req_to", 1'b0, 3'b010, 32'h80, 32'h0, 32'h0, 1000, 0, 1'b0,
                   5, 4, 32'h80, 32'h0, 4'h0, 32'h0, 1'b1, 2'd2);

        // A late read response after the timeout must not produce anything.
        i_bus_rvalid = 1'b1;
        i_bus_rdata  = 32'h0BADBEEF;
        @(negedge i_clk);
        check("late_rvalid.resp_valid", 32'(o_resp_valid), 32'd0);
        check("late_rvalid.req_ready", 32'(o_req_ready), 32'd1);
        @(posedge i_clk); #1;
        bus_idle();
        @(negedge i_clk);
        check("late_rvalid.resp_valid_next", 32'(o_resp_valid), 32'd0);
        @(posedge i_clk); #1;

        run_access("lw_wait_to", 1'b0, 3'b010, 32'h84, 32'h0, 32'h0, 0, 1000, 1'b0,
                   5, 1, 32'h84, 32'h0, 4'h0, 32'h0, 1'b1, 2'd2);

`ifdef CPU_LSU_MISALIGN_EXC_EN
        run_access("lw_misal", 1'b0, 3'b010, 32'h102, 32'h0, 32'h11223344, 0, 0, 1'b0,
                   1, 0, 32'h0, 32'h0, 4'h0, 32'h0, 1'b1, 2'd3);
`else
        run_access("lw_misal", 1'b0, 3'b010, 32'h102, 32'h0, 32'h11223344, 0, 0, 1'b0,
                   2, 1, 32'h100, 32'h0, 4'h0, 32'h11223344, 1'b0, 2'd0);
`endif

        // Request held through DONE: not accepted until the following IDLE cycle.
        i_req_valid  = 1'b1;
        i_req_we     = 1'b1;
        i_req_funct3 = 3'b010;
        i_req_addr   = 32'h20;
        i_req_wdata  = 32'h01020304;
        @(posedge i_clk); #1;
        i_bus_ready = 1'b1;
        @(negedge i_clk);
        check("hold.req_stall", 32'(o_stall), 32'd1);
        check("hold.req_ready", 32'(o_req_ready), 32'd0);
        @(posedge i_clk); #1;
        i_bus_ready = 1'b0;
        @(negedge i_clk);
        check("hold.done_resp", 32'(o_resp_valid), 32'd1);
        check("hold.done_stall", 32'(o_stall), 32'd0);
        check("hold.done_ready", 32'(o_req_ready), 32'd0);
        @(posedge i_clk); #1;
        @(negedge i_clk);
        check("hold.idle_ready", 32'(o_req_ready), 32'd1);
        check("hold.idle_stall", 32'(o_stall), 32'd1);
        check("hold.idle_busv", 32'(o_bus_valid), 32'd0);
        @(posedge i_clk); #1;
        i_req_valid = 1'b0;
        i_bus_ready = 1'b1;
        @(negedge i_clk);
        check("hold.second_busv", 32'(o_bus_valid), 32'd1);
        @(posedge i_clk); #1;
        i_bus_ready = 1'b0;
        @(negedge i_clk);
        check("hold.second_resp", 32'(o_resp_valid), 32'd1);
        @(posedge i_clk); #1;

        // Reset while waiting for read data.
        i_req_valid  = 1'b1;
        i_req_we     = 1'b0;
        i_req_funct3 = 3'b010;
        i_req_addr   = 32'h60;
        @(posedge i_clk); #1;
        i_req_valid = 1'b0;
        i_bus_ready = 1'b1;
        @(posedge i_clk); #1;
        i_bus_ready = 1'b0;
        @(negedge i_clk);
        check("rst_wait.stall_before", 32'(o_stall), 32'd1);
        check("rst_wait.busv_in_wait", 32'(o_bus_valid), 32'd0);
        @(posedge i_clk); #1;
        i_rst = 1'b1;
        @(posedge i_clk); #1;
        i_rst = 1'b0;
        @(negedge i_clk);
        check("rst_wait.stall_after", 32'(o_stall), 32'd0);
        check("rst_wait.ready_after", 32'(o_req_ready), 32'd1);
        check("rst_wait.resp_after", 32'(o_resp_valid), 32'd0);
        @(posedge i_clk); #1;
        i_bus_rvalid = 1'b1;
        i_bus_rdata  = 32'hFEEDFACE;
        @(negedge i_clk);
        check("rst_wait.late_rvalid", 32'(o_resp_valid), 32'd0);
        @(posedge i_clk); #1;
        bus_idle();
        @(negedge i_clk);
        check("rst_wait.late_rvalid_next", 32'(o_resp_valid), 32'd0);
        check("rst_wait.idle_ready", 32'(o_req_ready), 32'd1);
        @(posedge i_clk); #1;

        // Normal operation resumes after the mid-access reset.
        run_access("post_rst_lw", 1'b0, 3'b010, 32'h64, 32'h0, 32'h0A0B0C0D, 0, 0, 1'b0,
                   2, 1, 32'h64, 32'h0, 4'h0, 32'h0A0B0C0D, 1'b0, 2'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
